aes_key_sched_ctrl: RTL
=======================

# aes_key_sched_ctrl

Sequential AES-128 key-schedule controller. It accepts a 128-bit cipher key over a valid/ready handshake and expands it iteratively, one 32-bit word per clock, into the 44-word schedule. The 11 round keys are held in an internal register file and served by round index to the cipher round engine. Round keys become readable as soon as they are complete, so encryption may begin before expansion finishes.

## Interface
Parameters:
- RK_REG, default 1: 1 registers `rk_out`/`rk_valid` (1-cycle read latency); 0 makes them combinational from `rk_idx`.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  `key_in` holds a new key
- key_ready  out  1  controller can accept a key (IDLE or DONE)
- key_in  in  128  key; key byte k is at `[8k+7:8k]`
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when w[43] is written
- rk_idx  in  4  requested round key, 0..10
- rk_out  out  128  round key r; `rk_out[32j+31:32j]` = w[4r+j]
- rk_valid  out  1  round key `rk_idx` is complete and stored
- zeroize  in  1  present only with KEYSCHED_ZEROIZE_EN

## Operation
- **Word packing:** w[i] = {byte 4i, byte 4i+1, byte 4i+2, byte 4i+3}, with byte 4i in bits 31:24.
- **States:** IDLE, EXPAND, DONE.
- **IDLE:** `key_ready`=1. On `key_valid && key_ready`:
  - load w[0..3] from `key_in`;
  - set the word counter i=4;
  - go to EXPAND.
- **EXPAND:** `key_ready`=0 and `busy`=1. Each cycle:
  - temp = w[i-1];
  - if i%4==0: temp = SubWord(RotWord(temp)) ^ {RCON[i/4], 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a};
  - w[i] = w[i-4] ^ temp;
  - i++ (6-bit counter).
  - After writing w[43], go to DONE and pulse `done`.
  - `key_valid` is ignored while in EXPAND.
- **DONE:** `key_ready`=1 and all round keys are valid. A new handshake reloads the key and returns to EXPAND. Old round keys 1..10 become invalid immediately, while round key 0 is valid at once.
- **Completion tracking:** `rounds_done` (4 bits) is 0 after a load and increments when w[4r+3] is written. `rk_valid` = (`rk_idx` <= `rounds_done`) && (`rk_idx` <= 10) && (a key has been loaded).
- **Out-of-range index:** `rk_idx` > 10 gives `rk_out`=0 and `rk_valid`=0.
- **Arithmetic:** all XOR, with no carries. RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.

## Timing
- **Reset:** state=IDLE, `key_ready`=1, `busy`=0, `done`=0, `rk_valid`=0, `rk_out`=0, and all w storage=0.
- **Load:** the handshake edge is cycle 0. w[4+n] is written at edge n+1, so w[43] is written at edge 40. `done`=1 in the cycle following edge 40 (one cycle only), and DONE is entered in that same cycle.
- **Round-key availability:** round key r (r>=1) is complete after edge 4r. It is visible on `rk_valid` immediately when RK_REG=0, or one cycle later when RK_REG=1.
- **Back-to-back keys:** `key_ready` is high during the `done` cycle, so the minimum key-to-key spacing is 41 cycles.
- **Reset mid-EXPAND:** reset clears everything asynchronously. No partial round key is ever reported valid.

## Configuration
- **KEYSCHED_ZEROIZE_EN defined:**
  - the `zeroize` port exists;
  - `zeroize`=1 in any state clears all w storage, `rounds_done`, `rk_valid` and `rk_out` at the next edge and forces IDLE;
  - it has priority over a simultaneous `key_valid` handshake;
  - `done` is not pulsed.
- **KEYSCHED_ZEROIZE_EN undefined:** there is no `zeroize` port, and keys persist until overwritten or reset.

## Structure
- **Package `aes_pkg`:**
  - AES_NK=4, AES_NR=10, AES_NW=44;
  - `aes_word_t` (32-bit) typedef;
  - RCON constant array;
  - state enum (IDLE/EXPAND/DONE).
- **Sub-module `aes_sbox`:** combinational 256-entry forward S-box, 8 in / 8 out. Instantiated four times for SubWord.
- Round-key register file is 11 x 128 bits, written one word at a time.

## Test plan
- **FIPS-197 key:** `key_in`=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b (2b7e1516... byte order).
  - After `done`: `rk_idx`=0 gives 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516.
  - `rk_idx`=10 gives 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8.
- **Early read:** hold `rk_idx`=1 from the handshake. `rk_valid` rises after edge 4 (+RK_REG), and `rk_out[31:0]`=32'ha0fafe17. `rk_idx`=2 stays invalid until edge 8.
- **Handshake timing:**
  - `key_ready`=0 for exactly edges 1..40;
  - `done` is high for one cycle after edge 40;
  - a `key_valid` pulse during EXPAND is ignored, and the round-10 key is unchanged.
- **Reset mid-op:** assert `rst_n`=0 at cycle 20. All outputs take their reset values, and `rk_valid`=0 for every `rk_idx`.
- **Back-to-back keys:** with all-zero then all-ff keys, `rk_idx`=10 after the second `done` matches the reference model. Round keys 1..10 are invalid during the second EXPAND.
- **Zeroize and range (with KEYSCHED_ZEROIZE_EN):**
  - `zeroize` at edge 10 drops `rk_valid` and forces IDLE;
  - `zeroize` coincident with a handshake leaves no key loaded;
  - `rk_idx`=11..15 always gives `rk_valid`=0 and `rk_out`=0.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 key-schedule constants, word type, controller state encoding and key byte packing.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_NK = 4;
    localparam int AES_NR = 10;
    localparam int AES_NW = 44;

    typedef logic [31:0] aes_word_t;

    // Indexed by i/4 of the word being expanded; entries 0 and 11..15 are never used.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Key byte k sits at [8k+7:8k]; word j gets bytes 4j..4j+3 with byte 4j in its top byte.
    function automatic logic [127:0] key_to_words(input logic [127:0] key);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < AES_NK; j++) begin
            for (int b = 0; b < 4; b++) begin
                w[32*j + 8*(3-b) +: 8] = key[8*(4*j+b) +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in and one byte out.
// Latency: purely combinational.
// Backpressure: none.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Row-major table, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n occupies bits [2047-8n -: 8]; 2047-8n is {~n, 3'b111}.
    assign dout = SBOX_TBL[{~din, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion, one schedule word per clock into an 11 x 128 round-key file; zeroize port under KEYSCHED_ZEROIZE_EN.
// Latency: w[43] lands 40 edges after the key handshake; round key r is readable after edge 4r (+1 when RK_REG=1).
// Backpressure: key_ready is low only while expanding; key_valid is ignored then, rk_idx reads never stall.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int RK_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid
`ifdef KEYSCHED_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    localparam logic [3:0] LAST_RK   = 4'(AES_NR);
    localparam logic [5:0] LAST_WORD = 6'(AES_NW - 1);

    logic zero_req;
`ifdef KEYSCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    ks_state_t        state_q, state_d;
    logic             load, step;
    logic [5:0]       word_cnt;
    logic [3:0]       rounds_done;
    logic             key_loaded;
    logic             done_q;
    logic [3:0][31:0] rk_mem [0:AES_NR];

    logic [5:0]       prev_idx;
    aes_word_t        w_prev, w_back, w_rot, w_sub, w_temp, w_new;
    logic             in_range, rd_valid;
    logic [127:0]     rd_key;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus load/step strobes; zeroize overrides everything, including a handshake.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (word_cnt == LAST_WORD) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (zero_req) begin
            load    = 1'b0;
            step    = 1'b0;
            state_d = IDLE;
        end
    end

    assign key_ready = (state_q != EXPAND);
    assign busy      = (state_q == EXPAND);
    assign done      = done_q;

    // w[i-1] and w[i-4] come straight out of the round-key file.
    assign prev_idx = word_cnt - 6'd1;
    assign w_prev   = rk_mem[prev_idx[5:2]][prev_idx[1:0]];
    assign w_back   = rk_mem[word_cnt[5:2] - 4'd1][word_cnt[1:0]];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (w_rot[8*b +: 8]),
            .dout (w_sub[8*b +: 8])
        );
    end

    assign w_temp = (word_cnt[1:0] == 2'd0) ? (w_sub ^ {RCON[word_cnt[5:2]], 24'h0}) : w_prev;
    assign w_new  = w_back ^ w_temp;

    // Round-key file, word counter and completion tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= AES_NR; r++) begin
                rk_mem[r] <= '0;
            end
            word_cnt    <= '0;
            rounds_done <= '0;
            key_loaded  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= step && (word_cnt == LAST_WORD);
            if (zero_req) begin
                for (int r = 0; r <= AES_NR; r++) begin
                    rk_mem[r] <= '0;
                end
                word_cnt    <= '0;
                rounds_done <= '0;
                key_loaded  <= 1'b0;
            end else if (load) begin
                // Only round 0 is rewritten; rounds 1..10 go stale but rounds_done hides them.
                rk_mem[0]   <= key_to_words(key_in);
                word_cnt    <= 6'd4;
                rounds_done <= '0;
                key_loaded  <= 1'b1;
            end else if (step) begin
                rk_mem[word_cnt[5:2]][word_cnt[1:0]] <= w_new;
                word_cnt <= word_cnt + 6'd1;
                if (word_cnt[1:0] == 2'd3) begin
                    rounds_done <= rounds_done + 4'd1;
                end
            end
        end
    end

    assign in_range = (rk_idx <= LAST_RK);
    assign rd_valid = key_loaded && in_range && (rk_idx <= rounds_done);
    assign rd_key   = in_range ? rk_mem[rk_idx] : '0;

    if (RK_REG != 0) begin : g_rk_reg
        logic [127:0] rk_out_q;
        logic         rk_valid_q;

        // Registered read port; zeroize wipes it together with the file.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rk_out_q   <= '0;
                rk_valid_q <= 1'b0;
            end else if (zero_req) begin
                rk_out_q   <= '0;
                rk_valid_q <= 1'b0;
            end else begin
                rk_out_q   <= rd_key;
                rk_valid_q <= rd_valid;
            end
        end

        assign rk_out   = rk_out_q;
        assign rk_valid = rk_valid_q;
    end else begin : g_rk_comb
        assign rk_out   = rd_key;
        assign rk_valid = rd_valid;
    end

endmodule
